// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 8-digit time-multiplexed display scanner with double-buffered data.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module digit_scan_ctrl #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    output logic [2:0]  sel,
    output logic [3:0]  hex,
    output logic        dp,
    output logic        blank,
    output logic        frame_done,
    output logic        pending
);
    localparam int DW = $clog2(TICK_DIV);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [2:0]    sel_n;
    logic [31:0]   shadow, active, active_n;
    logic [7:0]    shadow_dp, active_dp, active_dp_n;
    logic          scanning, tick, wrap, xfer, blank_n;
`ifdef LEAD_ZERO_BLANK_EN
    logic [2:0]    hi;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            sel        <= '0;
            hex        <= '0;
            dp         <= 1'b0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            shadow     <= '0;
            shadow_dp  <= '0;
            active     <= '0;
            active_dp  <= '0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            sel        <= sel_n;
            hex        <= active_n[{sel_n, 2'b00} +: 4];
            dp         <= active_dp_n[sel_n];
            blank      <= blank_n;
            frame_done <= wrap;
            pending    <= load | (pending & ~xfer);
            active     <= active_n;
            active_dp  <= active_dp_n;
            if (load) begin
                shadow    <= data_in;
                shadow_dp <= dp_in;
            end
        end
    end
    // Outputs are registered from next-state values so sel/hex/dp/blank move together.
    always_comb begin
        state_n     = en ? SCAN : IDLE;
        scanning    = (state == SCAN) && en;
        tick        = (state == SCAN) && (div == DW'(TICK_DIV - 1));
        wrap        = scanning && tick && (sel == 3'd7);
        xfer        = pending && (wrap || state == IDLE);
        div_n       = (scanning && !tick) ? div + DW'(1) : '0;
        sel_n       = scanning ? sel + 3'(tick) : 3'd0;
        active_n    = xfer ? shadow : active;
        active_dp_n = xfer ? shadow_dp : active_dp;
`ifdef LEAD_ZERO_BLANK_EN
        hi = 3'd0;
        for (int k = 1; k < 8; k++)
            if (active_n[4*k +: 4] != 4'd0) hi = 3'(k);
        blank_n = (state_n == IDLE) || ((sel_n > hi) && !active_dp_n[sel_n]);
`else
        blank_n = (state_n == IDLE);
`endif
    end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: vector table, directed corner sequences and random stimulus
// checked against a frame-level behavioural model of the display scanner.
module tb_digit_scan_ctrl;
    localparam int TD = 4;
`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    logic clk = 1'b0, rst, en, load, dp, blank, frame_done, pending;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [2:0]  sel;
    logic [3:0]  hex;
    int n_tests = 0, n_fail = 0;

    digit_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in), .dp_in(dp_in),
        .sel(sel), .hex(hex), .dp(dp), .blank(blank), .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    // Model: time spent scanning determines the digit; buffers are plain words.
    bit          m_scan;
    int          m_cnt;
    logic [31:0] m_act, m_sh;
    logic [7:0]  m_adp, m_shdp;
    logic        m_pend, m_fd, m_dp, m_blank;
    logic [2:0]  m_sel;
    logic [3:0]  m_hex;

    task automatic model_edge(input logic r, e, l, input logic [31:0] d, input logic [7:0] p);
        bit wrap, xfer, zeros_above;
        if (r) begin
            m_scan = 0; m_cnt = 0; m_act = 0; m_sh = 0; m_adp = 0; m_shdp = 0;
            m_pend = 0; wrap = 0;
        end else begin
            wrap = m_scan && e && ((m_cnt + 1) % (8 * TD) == 0);
            xfer = m_pend && (wrap || !m_scan);
            if (xfer) begin m_act = m_sh; m_adp = m_shdp; end
            if (l) begin m_sh = d; m_shdp = p; end
            m_pend = l ? 1'b1 : (xfer ? 1'b0 : m_pend);
            if (m_scan && e) m_cnt++;
            else begin m_scan = e; m_cnt = 0; end
        end
        m_sel = m_scan ? 3'((m_cnt / TD) % 8) : 3'd0;
        m_hex = m_act[4*m_sel +: 4];
        m_dp  = m_adp[m_sel];
        m_fd  = wrap;
        zeros_above = 1;
        for (int j = 0; j < 8; j++) if (j >= m_sel && m_act[4*j +: 4] != 0) zeros_above = 0;
        m_blank = !m_scan || (LZB && m_sel != 0 && zeros_above && !m_adp[m_sel]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, e, l, input logic [31:0] d, input logic [7:0] p);
        rst = r; en = e; load = l; data_in = d; dp_in = p;
        @(posedge clk);
        model_edge(r, e, l, d, p);
        @(negedge clk);
        check("model", {21'd0, sel, hex, dp, blank, frame_done, pending},
              {21'd0, m_sel, m_hex, m_dp, m_blank, m_fd, m_pend});
    endtask

    task automatic run_until(input logic [2:0] s);
        int i;
        for (i = 0; i < 200 && sel !== s; i++) step(0, 1, 0, 0, 0);
        if (sel !== s) check("timeout_sel", {29'd0, sel}, {29'd0, s});
    endtask

    typedef struct {
        logic r, e, l; logic [31:0] d; logic [7:0] p;
        logic [2:0] sel; logic [3:0] hex; logic dp, blank, fd, pend;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int fd_cnt;
        logic [7:0] seen;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        8'h00, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'hFF, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h12345678, 8'h01, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h00, 3'd0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 3'd0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 3'd0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 3'd0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 3'd0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 3'd1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h00, 3'd0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d, tbl[i].p);
            check($sformatf("vec%0d", i), {21'd0, sel, hex, dp, blank, frame_done, pending},
                  {21'd0, tbl[i].sel, tbl[i].hex, tbl[i].dp, tbl[i].blank, tbl[i].fd, tbl[i].pend});
        end

        // IDLE to SCAN: two frame_done pulses across 65 scanning cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        fd_cnt = 0;
        for (int i = 0; i < 65; i++) begin
            step(0, 1, 0, 0, 0);
            if (frame_done) fd_cnt++;
        end
        check("fd_count", fd_cnt, 2);

        // Frame-boundary transfer
        step(0, 1, 1, 32'hFFFFFFFF, 8'h00);
        run_until(1);
        run_until(0);
        run_until(3);
        step(0, 1, 1, 32'h87654321, 8'h00);
        check("pend_after_load", {31'd0, pending}, 1);
        run_until(7);
        check("hex_old_at7", {28'd0, hex}, 32'hF);
        run_until(0);
        check("hex_new_at0", {28'd0, hex}, 1);
        check("pend_clear_at0", {31'd0, pending}, 0);
        run_until(7);
        check("hex_new_at7", {28'd0, hex}, 8);

        // Load coinciding with the wrap (currently first cycle of digit 7)
        step(0, 1, 1, 32'hAAAAAAAA, 8'h00);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h55555555, 8'h00);
        check("wrap_load", {24'd0, sel, hex, frame_done, pending}, {24'd0, 3'd0, 4'hA, 1'b1, 1'b1});
        run_until(7);
        check("wrap_frame_a", {28'd0, hex}, 32'hA);
        run_until(0);
        check("next_frame_5", {24'd0, 3'd0, hex, 1'b0, pending}, {24'd0, 3'd0, 4'h5, 1'b0, 1'b0});

        // Enable drop and reset mid-frame
        run_until(5);
        step(0, 0, 0, 0, 0);
        check("en_drop", {28'd0, sel, blank, frame_done}, {28'd0, 3'd0, 1'b1, 1'b0});
        run_until(6);
        step(1, 1, 1, 32'h99999999, 8'hFF);
        check("rst_mid", {21'd0, sel, hex, dp, blank, frame_done, pending},
              {21'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        step(0, 0, 0, 0, 0);
        check("rst_load_dropped", {27'd0, hex, pending}, 0);

        // Leading-zero blanking pattern
        step(0, 0, 1, 32'h00000305, 8'h20);
        step(0, 0, 0, 0, 0);
        seen = 8'h00;
        for (int i = 0; i < 8 * TD; i++) begin
            step(0, 1, 0, 0, 0);
            seen[sel] = blank;
        end
        check("lzb_mask", {24'd0, seen}, LZB ? 32'hD8 : 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            d = $urandom >> (4 * $urandom_range(0, 8));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                 d, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
